// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM states, mux/ALU codes.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [2:0] OP_IALU_PFX = 3'b001;

    // Controller states; the encoding is visible on state_dbg
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StWbR    = 4'd3,
        StExecI  = 4'd4,
        StWbI    = 4'd5,
        StAddr   = 4'd6,
        StMemRd  = 4'd7,
        StWbLd   = 4'd8,
        StMemWr  = 4'd9,
        StBr     = 4'd10,
        StJmp    = 4'd11,
        StErr    = 4'd12
    } state_e;

    // alu_op
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluImm   = 2'b11;

    // alu_src_b
    localparam logic [1:0] SrcBRt    = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // pc_src
    localparam logic [1:0] PcSrcAlu = 2'b00;
    localparam logic [1:0] PcSrcBr  = 2'b01;
    localparam logic [1:0] PcSrcJmp = 2'b10;

    // reg_dst
    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    // mem_to_reg
    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMdr = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    // One-hot opcode class
    typedef struct packed {
        logic r;
        logic ialu;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational opcode classifier producing exactly one class bit.
module mips_op_classify
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    // I-ALU is a whole prefix group; everything else is matched exactly
    always_comb begin
        cls = '0;
        if (opcode[5:3] == OP_IALU_PFX) begin
            cls.ialu = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: cls.r       = 1'b1;
                OP_LW:    cls.lw      = 1'b1;
                OP_SW:    cls.sw      = 1'b1;
                OP_BEQ:   cls.beq     = 1'b1;
                OP_J:     cls.j       = 1'b1;
                OP_JAL:   cls.jal     = 1'b1;
                default:  cls.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: FSM, memory-wait watchdog and datapath control decode.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_dbg
);

    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    op_class_t       cls;
    logic            waiting;
    logic            expired;

    mips_op_classify u_classify (
        .opcode (opcode),
        .cls    (cls)
    );

    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // A ready in the last allowed cycle still completes the request
    assign expired = waiting && !mem_ready && (cnt_q == CntW'(WAIT_MAX - 1));

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state; counter is zero outside a stalled request, so every wait state starts at 0
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        if (waiting && !mem_ready) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (expired) begin
            state_d   = StErr;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                StFetch:  if (mem_ready) state_d = StDecode;
                StDecode: begin
                    unique case (1'b1)
                        cls.r:          state_d = StExecR;
                        cls.ialu:       state_d = StExecI;
                        cls.lw, cls.sw: state_d = StAddr;
                        cls.beq:        state_d = StBr;
                        cls.j, cls.jal: state_d = StJmp;
                        cls.illegal: begin
                            state_d   = StErr;
                            illegal_d = 1'b1;
                        end
                        default: begin
                            state_d   = StErr;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                StExecR:  state_d = StWbR;
                StWbR:    state_d = StFetch;
                StExecI:  state_d = StWbI;
                StWbI:    state_d = StFetch;
                StAddr:   state_d = cls.lw ? StMemRd : StMemWr;
                StMemRd:  if (mem_ready) state_d = StWbLd;
                StWbLd:   state_d = StFetch;
                StMemWr:  if (mem_ready) state_d = StFetch;
                StBr:     state_d = StFetch;
                StJmp:    state_d = StFetch;
                StErr:    state_d = StErr;
                default:  state_d = StErr;
            endcase
        end
    end

    // Datapath controls from the current state; strobes qualified by ready/zero/jal
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PcSrcAlu;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBRt;
        alu_op     = AluAdd;
        reg_write  = 1'b0;
        reg_dst    = RegDstRt;
        mem_to_reg = MemToRegAlu;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StDecode: alu_src_b = SrcBImmSh;
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = RegDstRd;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluImm;
            end
            StWbI: reg_write = 1'b1;
            StAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRd: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            StWbLd: begin
                reg_write  = 1'b1;
                mem_to_reg = MemToRegMdr;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            StBr: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_src    = PcSrcBr;
                pc_write  = zero;
            end
            StJmp: begin
                pc_src   = PcSrcJmp;
                pc_write = 1'b1;
                if (cls.jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = RegDstRa;
                    mem_to_reg = MemToRegPc;
                end
            end
            default: ;
        endcase
    end

    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule
